// File: rtl/chng_rec_seq.sv
// Change-record sequencer: walks the change memory one record at a time and
// holds each record on chng_* until the compute chain reports it fully applied.
module chng_rec_seq #(
  parameter int unsigned ADDR_W       = 10,
  parameter logic [15:0] SENTINEL_ROW = 16'hFFFF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   num_rec,
  output logic              cmem_rd_en,
  output logic [ADDR_W-1:0] cmem_addr,
  input  logic [79:0]       cmem_rdata,
  output logic [15:0]       chng_row,
  output logic [15:0]       chng_col,
  output logic [23:0]       chng_real,
  output logic [23:0]       chng_img,
  output logic              chng_valid,
  input  logic              comp_done,
  output logic              busy,
  output logic              all_done,
  output logic [ADDR_W-1:0] rec_idx
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, RD, CAP, PRES, NEXT, DONE} state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  count_sat_c;
  logic [ADDR_W-1:0] rec_idx_d;
  logic              last_c;
  logic              rd_en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [15:0]       row_d;
  logic [15:0]       col_d;
  logic [23:0]       real_d;
  logic [23:0]       img_d;
  logic              valid_d;
  logic              busy_d;
  logic              all_done_d;

  // Oversized requests saturate so rec_idx can never wrap.
  assign count_sat_c = (num_rec > MAX_CNT) ? MAX_CNT : num_rec;
  assign last_c      = (({1'b0, rec_idx} + CNT_W'(1)) == count);

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      rec_idx    <= '0;
      cmem_rd_en <= 1'b0;
      cmem_addr  <= '0;
      chng_row   <= '0;
      chng_col   <= '0;
      chng_real  <= '0;
      chng_img   <= '0;
      chng_valid <= 1'b0;
      busy       <= 1'b0;
      all_done   <= 1'b0;
    end else begin
      state      <= state_d;
      count      <= count_d;
      rec_idx    <= rec_idx_d;
      cmem_rd_en <= rd_en_d;
      cmem_addr  <= addr_d;
      chng_row   <= row_d;
      chng_col   <= col_d;
      chng_real  <= real_d;
      chng_img   <= img_d;
      chng_valid <= valid_d;
      busy       <= busy_d;
      all_done   <= all_done_d;
    end
  end

  // Next-state logic; comp_done only matters in PRES.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (start) state_d = (num_rec == '0) ? DONE : RD;
      RD:   state_d = CAP;
      CAP:  state_d = (cmem_rdata[79:64] == SENTINEL_ROW) ? DONE : PRES;
      PRES: if (comp_done) state_d = NEXT;
      NEXT: state_d = last_c ? DONE : RD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs, keyed off the state being entered.
  always_comb begin
    count_d   = count;
    rec_idx_d = rec_idx;
    row_d     = chng_row;
    col_d     = chng_col;
    real_d    = chng_real;
    img_d     = chng_img;

    if (state == IDLE && start) begin
      count_d   = count_sat_c;
      rec_idx_d = '0;
    end
    if (state == NEXT && !last_c) begin
      rec_idx_d = rec_idx + ADDR_W'(1);
    end

    if (state_d != PRES) begin
      row_d  = '0;
      col_d  = '0;
      real_d = '0;
      img_d  = '0;
    end else if (state == CAP) begin
      row_d  = cmem_rdata[79:64];
      col_d  = cmem_rdata[63:48];
      real_d = cmem_rdata[47:24];
      img_d  = cmem_rdata[23:0];
    end

    rd_en_d    = (state_d == RD);
    addr_d     = rd_en_d ? rec_idx_d : '0;
    valid_d    = (state_d == PRES);
    busy_d     = (state_d != IDLE);
    all_done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_chng_rec_seq.sv
// Directed bench for chng_rec_seq: behavioural change memory plus a negedge
// monitor that records every presented record and all_done pulse.
module tb_chng_rec_seq;

  localparam int unsigned ADDR_W = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   num_rec = '0;
  logic              cmem_rd_en;
  logic [ADDR_W-1:0] cmem_addr;
  logic [79:0]       cmem_rdata = '0;
  logic [15:0]       chng_row;
  logic [15:0]       chng_col;
  logic [23:0]       chng_real;
  logic [23:0]       chng_img;
  logic              chng_valid;
  logic              comp_done = 1'b0;
  logic              busy;
  logic              all_done;
  logic [ADDR_W-1:0] rec_idx;

  int checks = 0;
  int failures = 0;

  logic [79:0] mem [0:1023];

  int          win_cnt = 0;
  int          valid_cyc = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  logic        prev_valid = 1'b0;
  logic [15:0] row_q [$];

  chng_rec_seq #(.ADDR_W(ADDR_W), .SENTINEL_ROW(16'hFFFF)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_rec    (num_rec),
    .cmem_rd_en (cmem_rd_en),
    .cmem_addr  (cmem_addr),
    .cmem_rdata (cmem_rdata),
    .chng_row   (chng_row),
    .chng_col   (chng_col),
    .chng_real  (chng_real),
    .chng_img   (chng_img),
    .chng_valid (chng_valid),
    .comp_done  (comp_done),
    .busy       (busy),
    .all_done   (all_done),
    .rec_idx    (rec_idx)
  );

  always #5 clock = ~clock;

  // Change memory: one-cycle read latency.
  always @(posedge clock) begin
    if (cmem_rd_en) cmem_rdata <= mem[cmem_addr];
  end

  always @(negedge clock) begin
    if (chng_valid && !prev_valid) begin
      win_cnt = win_cnt + 1;
      row_q.push_back(chng_row);
    end
    if (chng_valid) valid_cyc = valid_cyc + 1;
    if (all_done) done_cnt = done_cnt + 1;
    if (cmem_rd_en) rd_cnt = rd_cnt + 1;
    prev_valid = chng_valid;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (chng_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (chng_valid) ok = 1'b1;
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!all_done && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic pulse_done();
    comp_done = 1'b1;
    step();
    comp_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({cmem_rd_en, cmem_addr, chng_row, chng_col, chng_real, chng_img,
         chng_valid, busy, all_done, rec_idx} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rd=%0b addr=%0h row=%0h valid=%0b busy=%0b done=%0b idx=%0h exp all zero",
               cmem_rd_en, cmem_addr, chng_row, chng_valid, busy, all_done, rec_idx);
    end
    num_rec = 11'd1;
    start = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || cmem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_beats_start got busy=%0b rd=%0b exp 0 0", busy, cmem_rd_en);
    end
    start = 1'b0;
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%0b exp 0", busy);
    end
  endtask

  task automatic test_single();
    mem[0] = {16'd3, 16'd5, 24'h000100, 24'hFFFF00};
    num_rec = 11'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (cmem_rd_en !== 1'b1 || cmem_addr !== 10'd0 || busy !== 1'b1 || rec_idx !== 10'd0) begin
      failures++;
      $display("FAIL single_rd got rd=%0b addr=%0d busy=%0b idx=%0d exp 1 0 1 0",
               cmem_rd_en, cmem_addr, busy, rec_idx);
    end
    // comp_done sampled on the edge where valid rises must be ignored
    comp_done = 1'b1;
    step();
    checks++;
    if (chng_valid !== 1'b0 || cmem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL single_cap got valid=%0b rd=%0b exp 0 0", chng_valid, cmem_rd_en);
    end
    step();
    comp_done = 1'b0;
    checks++;
    if (chng_valid !== 1'b1 || chng_row !== 16'd3 || chng_col !== 16'd5 ||
        chng_real !== 24'h000100 || chng_img !== 24'hFFFF00) begin
      failures++;
      $display("FAIL single_present got valid=%0b row=%0h col=%0h re=%0h im=%0h exp 1 3 5 100 ffff00",
               chng_valid, chng_row, chng_col, chng_real, chng_img);
    end
    step();
    step();
    step();
    checks++;
    if (chng_valid !== 1'b1 || chng_row !== 16'd3 || chng_img !== 24'hFFFF00) begin
      failures++;
      $display("FAIL single_hold got valid=%0b row=%0h im=%0h exp 1 3 ffff00",
               chng_valid, chng_row, chng_img);
    end
    pulse_done();
    checks++;
    if (chng_valid !== 1'b0 || chng_row !== 16'd0 || chng_img !== 24'd0 ||
        all_done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_release got valid=%0b row=%0h im=%0h done=%0b busy=%0b exp 0 0 0 0 1",
               chng_valid, chng_row, chng_img, all_done, busy);
    end
    step();
    checks++;
    if (all_done !== 1'b1 || busy !== 1'b1 || rec_idx !== 10'd0) begin
      failures++;
      $display("FAIL single_all_done got done=%0b busy=%0b idx=%0d exp 1 1 0", all_done, busy, rec_idx);
    end
    step();
    checks++;
    if (all_done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got done=%0b busy=%0b exp 0 0", all_done, busy);
    end
  endtask

  task automatic test_three();
    int delays [3] = '{0, 7, 20};
    int w0, d0, q0, n;
    bit ok;
    for (int i = 0; i < 3; i++) mem[i] = {16'(10 + i), 16'(100 + i), 24'(i), 24'(i + 5)};
    w0 = win_cnt;
    d0 = done_cnt;
    q0 = row_q.size();
    num_rec = 11'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_valid(10, ok);
      checks++;
      if (!ok || chng_row !== 16'(10 + i) || chng_col !== 16'(100 + i) || rec_idx !== 10'(i)) begin
        failures++;
        $display("FAIL three_rec%0d got ok=%0b row=%0d col=%0d idx=%0d exp 1 %0d %0d %0d",
                 i, ok, chng_row, chng_col, rec_idx, 10 + i, 100 + i, i);
      end
      for (int k = 0; k < delays[i]; k++) step();
      checks++;
      if (chng_valid !== 1'b1) begin
        failures++;
        $display("FAIL three_hold%0d got valid=%0b exp 1", i, chng_valid);
      end
      pulse_done();
    end
    wait_done(10, n);
    checks++;
    if (all_done !== 1'b1 || rec_idx !== 10'd2) begin
      failures++;
      $display("FAIL three_done got done=%0b idx=%0d exp 1 2", all_done, rec_idx);
    end
    step();
    step();
    checks++;
    if (win_cnt - w0 !== 3 || done_cnt - d0 !== 1 || row_q.size() - q0 !== 3) begin
      failures++;
      $display("FAIL three_counts got windows=%0d dones=%0d exp 3 1", win_cnt - w0, done_cnt - d0);
    end else begin
      checks++;
      if (row_q[q0] !== 16'd10 || row_q[q0+1] !== 16'd11 || row_q[q0+2] !== 16'd12) begin
        failures++;
        $display("FAIL three_order got %0d %0d %0d exp 10 11 12", row_q[q0], row_q[q0+1], row_q[q0+2]);
      end
    end
  endtask

  task automatic test_sentinel();
    int w0, r0, n;
    bit ok;
    mem[0] = {16'd20, 16'd0, 24'd0, 24'd0};
    mem[1] = {16'd21, 16'd0, 24'd0, 24'd0};
    mem[2] = {16'hFFFF, 16'd7, 24'd7, 24'd7};
    mem[3] = {16'd23, 16'd0, 24'd0, 24'd0};
    mem[4] = {16'd24, 16'd0, 24'd0, 24'd0};
    w0 = win_cnt;
    r0 = rd_cnt;
    num_rec = 11'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wait_valid(10, ok);
      checks++;
      if (!ok || chng_row !== 16'(20 + i)) begin
        failures++;
        $display("FAIL sentinel_rec%0d got ok=%0b row=%0d exp 1 %0d", i, ok, chng_row, 20 + i);
      end
      pulse_done();
    end
    wait_done(10, n);
    checks++;
    if (n !== 3 || all_done !== 1'b1 || rec_idx !== 10'd2 || chng_valid !== 1'b0) begin
      failures++;
      $display("FAIL sentinel_done got cycles=%0d done=%0b idx=%0d valid=%0b exp 3 1 2 0",
               n, all_done, rec_idx, chng_valid);
    end
    step();
    checks++;
    if (win_cnt - w0 !== 2 || rd_cnt - r0 !== 3 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sentinel_counts got windows=%0d reads=%0d busy=%0b exp 2 3 0",
               win_cnt - w0, rd_cnt - r0, busy);
    end
  endtask

  task automatic test_zero();
    int r0;
    r0 = rd_cnt;
    num_rec = 11'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (all_done !== 1'b1 || busy !== 1'b1 || cmem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL zero_done got done=%0b busy=%0b rd=%0b exp 1 1 0", all_done, busy, cmem_rd_en);
    end
    step();
    step();
    checks++;
    if (all_done !== 1'b0 || busy !== 1'b0 || rd_cnt !== r0) begin
      failures++;
      $display("FAIL zero_idle got done=%0b busy=%0b reads=%0d exp 0 0 0", all_done, busy, rd_cnt - r0);
    end
  endtask

  task automatic test_start_in_pres();
    int n;
    bit ok;
    mem[0] = {16'd30, 16'd0, 24'd0, 24'd0};
    mem[1] = {16'd31, 16'd0, 24'd0, 24'd0};
    num_rec = 11'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(10, ok);
    num_rec = 11'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (!ok || chng_valid !== 1'b1 || chng_row !== 16'd30 || rec_idx !== 10'd0) begin
      failures++;
      $display("FAIL start_in_pres got valid=%0b row=%0d idx=%0d exp 1 30 0", chng_valid, chng_row, rec_idx);
    end
    pulse_done();
    wait_valid(10, ok);
    checks++;
    if (!ok || chng_row !== 16'd31) begin
      failures++;
      $display("FAIL start_no_resample got ok=%0b row=%0d exp 1 31", ok, chng_row);
    end
    pulse_done();
    wait_done(10, n);
    checks++;
    if (all_done !== 1'b1 || rec_idx !== 10'd1) begin
      failures++;
      $display("FAIL start_in_pres_done got done=%0b idx=%0d exp 1 1", all_done, rec_idx);
    end
    step();
  endtask

  task automatic test_stuck_done();
    int w0, v0, q0, n;
    for (int i = 0; i < 3; i++) mem[i] = {16'(40 + i), 16'd0, 24'd0, 24'd0};
    w0 = win_cnt;
    v0 = valid_cyc;
    q0 = row_q.size();
    comp_done = 1'b1;
    num_rec = 11'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, n);
    comp_done = 1'b0;
    checks++;
    if (n !== 12 || all_done !== 1'b1) begin
      failures++;
      $display("FAIL stuck_timing got cycles=%0d done=%0b exp 12 1", n, all_done);
    end
    step();
    checks++;
    if (win_cnt - w0 !== 3 || valid_cyc - v0 !== 3 || row_q.size() - q0 !== 3) begin
      failures++;
      $display("FAIL stuck_windows got windows=%0d valid_cycles=%0d exp 3 3", win_cnt - w0, valid_cyc - v0);
    end else begin
      checks++;
      if (row_q[q0] !== 16'd40 || row_q[q0+1] !== 16'd41 || row_q[q0+2] !== 16'd42) begin
        failures++;
        $display("FAIL stuck_order got %0d %0d %0d exp 40 41 42", row_q[q0], row_q[q0+1], row_q[q0+2]);
      end
    end
  endtask

  task automatic test_reset_in_pres();
    int d0, n;
    bit ok;
    mem[0] = {16'd50, 16'd0, 24'd0, 24'd0};
    mem[1] = {16'd51, 16'd0, 24'd0, 24'd0};
    mem[2] = {16'd52, 16'd0, 24'd0, 24'd0};
    d0 = done_cnt;
    num_rec = 11'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_valid(10, ok);
    pulse_done();
    wait_valid(10, ok);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (!ok || chng_valid !== 1'b0 || chng_row !== 16'd0 || busy !== 1'b0 || rec_idx !== 10'd0) begin
      failures++;
      $display("FAIL reset_pres got valid=%0b row=%0d busy=%0b idx=%0d exp 0 0 0 0",
               chng_valid, chng_row, busy, rec_idx);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done got dones=%0d busy=%0b exp 0 0", done_cnt - d0, busy);
    end
    num_rec = 11'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (cmem_rd_en !== 1'b1 || cmem_addr !== 10'd0 || rec_idx !== 10'd0) begin
      failures++;
      $display("FAIL reset_restart got rd=%0b addr=%0d idx=%0d exp 1 0 0", cmem_rd_en, cmem_addr, rec_idx);
    end
    wait_valid(10, ok);
    checks++;
    if (!ok || chng_row !== 16'd50) begin
      failures++;
      $display("FAIL reset_restart_row got ok=%0b row=%0d exp 1 50", ok, chng_row);
    end
    pulse_done();
    wait_done(10, n);
    step();
  endtask

  task automatic test_saturate();
    int w0, r0, n;
    for (int i = 0; i < 1024; i++) mem[i] = {16'(i), 16'd0, 24'd0, 24'd0};
    w0 = win_cnt;
    r0 = rd_cnt;
    comp_done = 1'b1;
    num_rec = 11'd2047;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(5000, n);
    comp_done = 1'b0;
    checks++;
    if (n !== 4096 || all_done !== 1'b1 || rec_idx !== 10'd1023) begin
      failures++;
      $display("FAIL saturate_done got cycles=%0d done=%0b idx=%0d exp 4096 1 1023", n, all_done, rec_idx);
    end
    step();
    checks++;
    if (win_cnt - w0 !== 1024 || rd_cnt - r0 !== 1024 || busy !== 1'b0) begin
      failures++;
      $display("FAIL saturate_counts got windows=%0d reads=%0d busy=%0b exp 1024 1024 0",
               win_cnt - w0, rd_cnt - r0, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_three();
    test_sentinel();
    test_zero();
    test_start_in_pres();
    test_stuck_done();
    test_reset_in_pres();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chng_rec_seq.md
Name: chng_rec_seq

Overview:
- Upstream feeder for the Y-value filter stage.
- Walks the change-record memory (contents of change.txt, one 80-bit record per address) and presents one record at a time as chng_row/chng_col/chng_real/chng_img.
- Holds each record stable until the downstream compute chain signals that all iterations for that change are complete, then fetches the next record.
- Guarantees the filter stage never sees a new change while a computation is in progress.

Parameters:
- ADDR_W, 10, change-memory address width (max 2^ADDR_W records).
- SENTINEL_ROW, 16'hFFFF, row value marking end-of-list; such a record is never presented.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a pass over the change list.
- num_rec  in  ADDR_W+1  number of records to process; sampled only when start is accepted.
- cmem_rd_en  out  1  change-memory read enable.
- cmem_addr  out  ADDR_W  change-memory read address.
- cmem_rdata  in  80  record {row[79:64], col[63:48], real[47:24], img[23:0]}; valid the cycle after rd_en is sampled.
- chng_row  out  16  current change row.
- chng_col  out  16  current change column.
- chng_real  out  24  current change real part.
- chng_img  out  24  current change imaginary part.
- chng_valid  out  1  record outputs are valid and held.
- comp_done  in  1  pulse from the compute stage: current change fully applied.
- busy  out  1  high from the accepted start until the cycle all_done is asserted, inclusive.
- all_done  out  1  one-cycle pulse at the end of the pass.
- rec_idx  out  ADDR_W  index of the record being fetched or presented.

Behaviour:
- Reset (synchronous, active-high): state=IDLE.
  - All outputs are 0: cmem_rd_en, cmem_addr, chng_* , chng_valid, busy, all_done, rec_idx.
  - The latched count is cleared.
  - Reset asserted mid-pass aborts the pass at the next edge. No all_done is issued.
- All outputs are registered. chng_* are driven 0 whenever chng_valid=0; no tri-state values.
- FSM states: IDLE, RD, CAP, PRES, NEXT, DONE.
- IDLE:
  - On start=1, latch num_rec, clear rec_idx, set busy=1.
  - If num_rec=0, go to DONE. Otherwise go to RD.
- RD:
  - cmem_rd_en=1 and cmem_addr=rec_idx for exactly one cycle.
  - Go to CAP.
- CAP:
  - If cmem_rdata row == SENTINEL_ROW, go to DONE. The record is not presented.
  - Otherwise register the fields into chng_*, set chng_valid=1, and go to PRES.
- PRES:
  - Hold chng_* and chng_valid=1 until comp_done=1 is sampled.
  - Then clear chng_valid and chng_* and go to NEXT.
- NEXT:
  - If rec_idx+1 == latched count, go to DONE.
  - Otherwise rec_idx<=rec_idx+1 and go to RD.
- DONE:
  - all_done=1 for one cycle; busy=1 in this cycle.
  - Return to IDLE; busy=0 from the following cycle.
- Latency:
  - start sampled at edge E0: cmem_rd_en high after E0, chng_valid high after E2.
  - comp_done sampled at edge Ek: chng_valid low after Ek, next chng_valid high after Ek+3.
- Boundary conditions:
  - start while busy: ignored; num_rec is not re-sampled.
  - comp_done outside PRES: ignored.
  - comp_done asserted in the same cycle chng_valid rises: ignored. It is sampled only when state is PRES.
  - comp_done held high for multiple cycles: consumed once. The next record still requires PRES to be reached, and a comp_done still high then advances it.
  - num_rec > 2^ADDR_W: saturate the latched count to 2^ADDR_W. rec_idx never wraps.
  - start and reset in the same cycle: reset wins.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → all outputs 0. start with reset=1 → stays IDLE, busy=0.
- Single record: mem[0]={16'd3,16'd5,24'h000100,24'hFFFF00}, num_rec=1, start at E0.
  - rd_en/addr=0 after E0; chng_valid=1 after E2 with row=3, col=5, real=0x000100, img=0xFFFF00, held until comp_done.
  - comp_done at Ek → chng_valid=0 after Ek, all_done pulse after Ek+1, busy=0 after Ek+2.
- Three records with comp_done delays of 0, 7 and 20 cycles → records presented in address order 0,1,2; exactly three valid windows; one all_done; rec_idx=2 at DONE.
- Sentinel: num_rec=5, mem[2].row=16'hFFFF → records 0 and 1 are presented, record 2 is never valid, and all_done follows CAP of index 2.
- num_rec=0 → all_done one cycle after start; cmem_rd_en never asserted.
- Abuse:
  - start pulse during PRES → ignored.
  - comp_done stuck high → one record per RD/CAP/PRES round trip.
  - reset in PRES → chng_valid=0 next cycle, no all_done, next start restarts at addr 0.
